// File: rtl/pipeline_pkg.sv
// ============================================================================
//  Package     : pipeline_pkg
//  Description : Shared types for the RV32I pipeline: control-word encodings,
//                the packed decode control word and its all-zero NOP value.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pipeline_pkg;

  // Write-back result source
  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10
  } result_src_t;

  // Jump kind
  typedef enum logic [1:0] {
    JUMP_NONE = 2'b00,
    JUMP_JAL  = 2'b01,
    JUMP_JALR = 2'b10
  } jump_t;

  // Memory operation code, zero means no memory access
  typedef enum logic [2:0] {
    MEM_NONE = 3'd0,
    MEM_SB   = 3'd1,
    MEM_SH   = 3'd2,
    MEM_SW   = 3'd3,
    MEM_LB   = 3'd4,
    MEM_LH   = 3'd5,
    MEM_LW   = 3'd6,
    MEM_LBU  = 3'd7
  } mem_op_t;

  // Decode-stage control word carried down the pipe
  typedef struct packed {
    logic        reg_write;
    result_src_t result_src;
    mem_op_t     mem_write;
    jump_t       jump;
    logic        branch;
    logic [2:0]  alu_control;
    logic        alu_src;
  } ctrl_word_t;

  localparam ctrl_word_t CTRL_NOP = '0;

  // An instruction whose result comes from memory is a load
  function automatic logic is_load(input result_src_t src);
    return (src == RES_MEM);
  endfunction

endpackage

`default_nettype wire

// File: rtl/load_use_detect.sv
// ============================================================================
//  Module      : load_use_detect
//  Description : Combinational load-use hazard check between the instruction
//                in EX and the one in decode. x0 never causes a hazard.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module load_use_detect
  import pipeline_pkg::*;
#(
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      valid_e,
  input  result_src_t               result_src_e,
  input  logic [REG_ADDR_WIDTH-1:0] rd_e,
  input  logic                      valid_d,
  input  logic [REG_ADDR_WIDTH-1:0] rs1_d,
  input  logic [REG_ADDR_WIDTH-1:0] rs2_d,
  output logic                      load_use
);

  logic rd_nonzero;
  logic src_match;

  assign rd_nonzero = (rd_e != '0);
  assign src_match  = (rs1_d == rd_e) | (rs2_d == rd_e);

  // A valid load in EX whose destination is read by the valid D instruction
  always_comb begin
    load_use = valid_e & is_load(result_src_e) & rd_nonzero & valid_d & src_match;
  end

endmodule

`default_nettype wire

// File: rtl/id_ex_stage_reg.sv
// ============================================================================
//  Module      : id_ex_stage_reg
//  Description : Decode-to-execute pipeline register with load-use bubble
//                insertion, flush and hold handling.
//                Optional macro ID_EX_PERF_CNT_EN adds bubble/flush counters.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module id_ex_stage_reg
  import pipeline_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      RegWriteD,
  input  logic [1:0]                ResultSrcD,
  input  logic [2:0]                MemWriteD,
  input  logic [1:0]                JumpD,
  input  logic                      BranchD,
  input  logic [2:0]                ALUControlD,
  input  logic                      ALUSrcD,
  input  logic [2:0]                Funct3D,
  input  logic [DATA_WIDTH-1:0]     RD1D,
  input  logic [DATA_WIDTH-1:0]     RD2D,
  input  logic [DATA_WIDTH-1:0]     ImmExtD,
  input  logic [ADDR_WIDTH-1:0]     PCD,
  input  logic [ADDR_WIDTH-1:0]     PCPlus4D,
  input  logic [REG_ADDR_WIDTH-1:0] Rs1D,
  input  logic [REG_ADDR_WIDTH-1:0] Rs2D,
  input  logic [REG_ADDR_WIDTH-1:0] RdD,
  input  logic                      ValidD,
  input  logic                      FlushE,
  input  logic                      StallE,
  output logic                      RegWriteE,
  output logic [1:0]                ResultSrcE,
  output logic [2:0]                MemWriteE,
  output logic [1:0]                JumpE,
  output logic                      BranchE,
  output logic [2:0]                ALUControlE,
  output logic                      ALUSrcE,
  output logic [2:0]                Funct3E,
  output logic [DATA_WIDTH-1:0]     RD1E,
  output logic [DATA_WIDTH-1:0]     RD2E,
  output logic [DATA_WIDTH-1:0]     ImmExtE,
  output logic [ADDR_WIDTH-1:0]     PCE,
  output logic [ADDR_WIDTH-1:0]     PCPlus4E,
  output logic [REG_ADDR_WIDTH-1:0] Rs1E,
  output logic [REG_ADDR_WIDTH-1:0] Rs2E,
  output logic [REG_ADDR_WIDTH-1:0] RdE,
  output logic                      ValidE,
  output logic                      StallF,
  output logic                      StallD,
  output logic                      BubbleE
`ifdef ID_EX_PERF_CNT_EN
  ,
  output logic [31:0]               BubbleCount,
  output logic [31:0]               FlushCount
`endif
);

  ctrl_word_t                ctrl_d;
  ctrl_word_t                ctrl_e;
  logic [2:0]                funct3_e;
  logic [DATA_WIDTH-1:0]     rd1_e;
  logic [DATA_WIDTH-1:0]     rd2_e;
  logic [DATA_WIDTH-1:0]     imm_e;
  logic [ADDR_WIDTH-1:0]     pc_e;
  logic [ADDR_WIDTH-1:0]     pc4_e;
  logic [REG_ADDR_WIDTH-1:0] rs1_e;
  logic [REG_ADDR_WIDTH-1:0] rs2_e;
  logic [REG_ADDR_WIDTH-1:0] rd_e;
  logic                      valid_e;
  logic                      bubble_e;
  logic                      load_use;
  logic                      insert_bubble;

  load_use_detect #(
    .REG_ADDR_WIDTH(REG_ADDR_WIDTH)
  ) u_load_use_detect (
    .valid_e      (valid_e),
    .result_src_e (ctrl_e.result_src),
    .rd_e         (rd_e),
    .valid_d      (ValidD),
    .rs1_d        (Rs1D),
    .rs2_d        (Rs2D),
    .load_use     (load_use)
  );

  // Pack decode controls; an invalid D slot carries a NOP so it has no side effects
  always_comb begin
    ctrl_d = CTRL_NOP;
    if (ValidD) begin
      ctrl_d.reg_write   = RegWriteD;
      ctrl_d.result_src  = result_src_t'(ResultSrcD);
      ctrl_d.mem_write   = mem_op_t'(MemWriteD);
      ctrl_d.jump        = jump_t'(JumpD);
      ctrl_d.branch      = BranchD;
      ctrl_d.alu_control = ALUControlD;
      ctrl_d.alu_src     = ALUSrcD;
    end
  end

  // Flush always bubbles; a load-use bubbles only when EX is not being held
  assign insert_bubble = FlushE | (load_use & ~StallE);

  // Freeze fetch/decode on a hazard or hold, but let a flush redirect proceed
  assign StallF = (load_use | StallE) & ~FlushE;
  assign StallD = (load_use | StallE) & ~FlushE;

  // EX register update: reset > bubble (flush / load-use) > hold > load
  always_ff @(posedge clk) begin
    if (rst || insert_bubble) begin
      ctrl_e   <= CTRL_NOP;
      funct3_e <= '0;
      rd1_e    <= '0;
      rd2_e    <= '0;
      imm_e    <= '0;
      pc_e     <= '0;
      pc4_e    <= '0;
      rs1_e    <= '0;
      rs2_e    <= '0;
      rd_e     <= '0;
      valid_e  <= 1'b0;
      bubble_e <= ~rst;
    end else if (StallE) begin
      bubble_e <= 1'b0;
    end else begin
      ctrl_e   <= ctrl_d;
      funct3_e <= Funct3D;
      rd1_e    <= RD1D;
      rd2_e    <= RD2D;
      imm_e    <= ImmExtD;
      pc_e     <= PCD;
      pc4_e    <= PCPlus4D;
      rs1_e    <= Rs1D;
      rs2_e    <= Rs2D;
      rd_e     <= RdD;
      valid_e  <= ValidD;
      bubble_e <= 1'b0;
    end
  end

`ifdef ID_EX_PERF_CNT_EN
  logic [31:0] bubble_cnt;
  logic [31:0] flush_cnt;

  // Count flushes and load-use bubbles separately; a coincident pair is a flush
  always_ff @(posedge clk) begin
    if (rst) begin
      bubble_cnt <= '0;
      flush_cnt  <= '0;
    end else if (FlushE) begin
      flush_cnt  <= flush_cnt + 32'd1;
    end else if (load_use && !StallE) begin
      bubble_cnt <= bubble_cnt + 32'd1;
    end
  end

  assign BubbleCount = bubble_cnt;
  assign FlushCount  = flush_cnt;
`endif

  assign RegWriteE   = ctrl_e.reg_write;
  assign ResultSrcE  = ctrl_e.result_src;
  assign MemWriteE   = ctrl_e.mem_write;
  assign JumpE       = ctrl_e.jump;
  assign BranchE     = ctrl_e.branch;
  assign ALUControlE = ctrl_e.alu_control;
  assign ALUSrcE     = ctrl_e.alu_src;
  assign Funct3E     = funct3_e;
  assign RD1E        = rd1_e;
  assign RD2E        = rd2_e;
  assign ImmExtE     = imm_e;
  assign PCE         = pc_e;
  assign PCPlus4E    = pc4_e;
  assign Rs1E        = rs1_e;
  assign Rs2E        = rs2_e;
  assign RdE         = rd_e;
  assign ValidE      = valid_e;
  assign BubbleE     = bubble_e;

endmodule

`default_nettype wire

// File: tb/tb_id_ex_stage_reg.sv
// ============================================================================
//  Module      : tb_id_ex_stage_reg
//  Description : Self-checking bench for id_ex_stage_reg: directed vector
//                table followed by randomized traffic against a reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_id_ex_stage_reg;

  logic        clk = 1'b0;
  logic        rst;
  logic        RegWriteD, BranchD, ALUSrcD, ValidD, FlushE, StallE;
  logic [1:0]  ResultSrcD, JumpD;
  logic [2:0]  MemWriteD, ALUControlD, Funct3D;
  logic [31:0] RD1D, RD2D, ImmExtD, PCD, PCPlus4D;
  logic [4:0]  Rs1D, Rs2D, RdD;
  logic        RegWriteE, BranchE, ALUSrcE, ValidE, StallF, StallD, BubbleE;
  logic [1:0]  ResultSrcE, JumpE;
  logic [2:0]  MemWriteE, ALUControlE, Funct3E;
  logic [31:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E;
  logic [4:0]  Rs1E, Rs2E, RdE;
`ifdef ID_EX_PERF_CNT_EN
  logic [31:0] BubbleCount, FlushCount;
`endif

  always #5 clk = ~clk;

  id_ex_stage_reg dut (
    .clk(clk), .rst(rst),
    .RegWriteD(RegWriteD), .ResultSrcD(ResultSrcD), .MemWriteD(MemWriteD),
    .JumpD(JumpD), .BranchD(BranchD), .ALUControlD(ALUControlD),
    .ALUSrcD(ALUSrcD), .Funct3D(Funct3D), .RD1D(RD1D), .RD2D(RD2D),
    .ImmExtD(ImmExtD), .PCD(PCD), .PCPlus4D(PCPlus4D),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD), .ValidD(ValidD),
    .FlushE(FlushE), .StallE(StallE),
    .RegWriteE(RegWriteE), .ResultSrcE(ResultSrcE), .MemWriteE(MemWriteE),
    .JumpE(JumpE), .BranchE(BranchE), .ALUControlE(ALUControlE),
    .ALUSrcE(ALUSrcE), .Funct3E(Funct3E), .RD1E(RD1E), .RD2E(RD2E),
    .ImmExtE(ImmExtE), .PCE(PCE), .PCPlus4E(PCPlus4E),
    .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .ValidE(ValidE),
    .StallF(StallF), .StallD(StallD), .BubbleE(BubbleE)
`ifdef ID_EX_PERF_CNT_EN
    , .BubbleCount(BubbleCount), .FlushCount(FlushCount)
`endif
  );

  // Complete EX-side state as seen by the outside world
  typedef struct packed {
    logic        regw;
    logic [1:0]  rsrc;
    logic [2:0]  memw;
    logic [1:0]  jump;
    logic        branch;
    logic [2:0]  aluc;
    logic        alusrc;
    logic [2:0]  f3;
    logic [31:0] rd1, rd2, imm, pc, pc4;
    logic [4:0]  rs1, rs2, rd;
    logic        valid;
    logic        bubble;
  } eout_t;

  // Directed vector: D-side stimulus plus the expected stall and EX result
  typedef struct {
    logic        rst, flush, stall, valid, regw;
    logic [1:0]  rsrc;
    logic [2:0]  memw;
    logic        alusrc;
    logic [31:0] imm;
    logic [4:0]  rs1, rs2, rd;
    logic        chk_stall, x_stall, x_regw;
    logic [1:0]  x_rsrc;
    logic [2:0]  x_memw;
    logic [4:0]  x_rd;
    logic [31:0] x_imm;
    logic        x_valid, x_bubble;
  } vec_t;

  vec_t  vecs[$];
  int    n_checks = 0;
  int    n_fail   = 0;
  eout_t model_e;
  logic [31:0] m_bubbles, m_flushes;

  function automatic vec_t row(
      logic r, logic fl, logic st, logic v, logic rw, logic [1:0] rs, logic [2:0] mw,
      logic as, logic [31:0] im, logic [4:0] a1, logic [4:0] a2, logic [4:0] d,
      logic cs, logic xs, logic xrw, logic [1:0] xrs, logic [2:0] xmw, logic [4:0] xd,
      logic [31:0] xim, logic xv, logic xb);
    vec_t t;
    t.rst = r; t.flush = fl; t.stall = st; t.valid = v; t.regw = rw; t.rsrc = rs;
    t.memw = mw; t.alusrc = as; t.imm = im; t.rs1 = a1; t.rs2 = a2; t.rd = d;
    t.chk_stall = cs; t.x_stall = xs; t.x_regw = xrw; t.x_rsrc = xrs; t.x_memw = xmw;
    t.x_rd = xd; t.x_imm = xim; t.x_valid = xv; t.x_bubble = xb;
    return t;
  endfunction

  function automatic eout_t dut_e();
    eout_t o;
    o = '{regw: RegWriteE, rsrc: ResultSrcE, memw: MemWriteE, jump: JumpE,
          branch: BranchE, aluc: ALUControlE, alusrc: ALUSrcE, f3: Funct3E,
          rd1: RD1E, rd2: RD2E, imm: ImmExtE, pc: PCE, pc4: PCPlus4E,
          rs1: Rs1E, rs2: Rs2E, rd: RdE, valid: ValidE, bubble: BubbleE};
    return o;
  endfunction

  // What D presents, expressed as the EX state it would become if loaded
  function automatic eout_t d_as_e();
    eout_t o;
    o = '{regw: RegWriteD, rsrc: ResultSrcD, memw: MemWriteD, jump: JumpD,
          branch: BranchD, aluc: ALUControlD, alusrc: ALUSrcD, f3: Funct3D,
          rd1: RD1D, rd2: RD2D, imm: ImmExtD, pc: PCD, pc4: PCPlus4D,
          rs1: Rs1D, rs2: Rs2D, rd: RdD, valid: ValidD, bubble: 1'b0};
    if (!ValidD) begin
      o.regw = 0; o.rsrc = 0; o.memw = 0; o.jump = 0;
      o.branch = 0; o.aluc = 0; o.alusrc = 0;
    end
    return o;
  endfunction

  function automatic logic model_hazard(eout_t e);
    return e.valid && (e.rsrc == 2'b01) && (e.rd != 0) && ValidD &&
           ((Rs1D == e.rd) || (Rs2D == e.rd));
  endfunction

  task automatic check1(string name, logic act, logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_e(string name, eout_t act, eout_t exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got rw=%b rs=%h mw=%h j=%h b=%b alu=%h as=%b f3=%h rd1=%h rd2=%h imm=%h pc=%h pc4=%h r1=%h r2=%h rd=%h v=%b bub=%b",
               name, act.regw, act.rsrc, act.memw, act.jump, act.branch, act.aluc, act.alusrc,
               act.f3, act.rd1, act.rd2, act.imm, act.pc, act.pc4, act.rs1, act.rs2, act.rd,
               act.valid, act.bubble);
      $display("     %s: expected rw=%b rs=%h mw=%h j=%h b=%b alu=%h as=%b f3=%h rd1=%h rd2=%h imm=%h pc=%h pc4=%h r1=%h r2=%h rd=%h v=%b bub=%b",
               name, exp.regw, exp.rsrc, exp.memw, exp.jump, exp.branch, exp.aluc, exp.alusrc,
               exp.f3, exp.rd1, exp.rd2, exp.imm, exp.pc, exp.pc4, exp.rs1, exp.rs2, exp.rd,
               exp.valid, exp.bubble);
    end
  endtask

  task automatic clear_inputs();
    rst = 0; FlushE = 0; StallE = 0; ValidD = 0;
    RegWriteD = 0; ResultSrcD = 0; MemWriteD = 0; JumpD = 0; BranchD = 0;
    ALUControlD = 0; ALUSrcD = 0; Funct3D = 0; RD1D = 0; RD2D = 0;
    ImmExtD = 0; PCD = 0; PCPlus4D = 0; Rs1D = 0; Rs2D = 0; RdD = 0;
  endtask

  task automatic randomize_inputs();
    rst        = ($urandom_range(0, 39) == 0);
    FlushE     = ($urandom_range(0, 7) == 0);
    StallE     = ($urandom_range(0, 5) == 0);
    ValidD     = ($urandom_range(0, 7) != 0);
    RegWriteD  = 1'($urandom);
    ResultSrcD = 2'($urandom_range(0, 2));
    MemWriteD  = 3'($urandom);
    JumpD      = 2'($urandom);
    BranchD    = 1'($urandom);
    ALUControlD = 3'($urandom);
    ALUSrcD    = 1'($urandom);
    Funct3D    = 3'($urandom);
    RD1D = $urandom; RD2D = $urandom; ImmExtD = $urandom;
    PCD = $urandom; PCPlus4D = PCD + 32'd4;
    Rs1D = 5'($urandom_range(0, 3));
    Rs2D = 5'($urandom_range(0, 3));
    RdD  = 5'($urandom_range(0, 3));
  endtask

  initial begin
    eout_t exp_e;
    logic  hz;
    logic  exp_stall;

    //         rst fl st v rw rs  mw as imm rs1 rs2 rd  cs xs  xrw xrs xmw xrd ximm xv xb
    vecs.push_back(row(1,0,0,1,1,2'd0,3'd0,0,32'd0, 5'd0,5'd0,5'd5,  0,0, 0,2'd0,3'd0,5'd0, 32'd0, 0,0));
    vecs.push_back(row(1,0,0,1,1,2'd0,3'd0,0,32'd0, 5'd0,5'd0,5'd5,  1,0, 0,2'd0,3'd0,5'd0, 32'd0, 0,0));
    vecs.push_back(row(0,0,0,1,1,2'd0,3'd0,1,32'd7, 5'd1,5'd0,5'd3,  1,0, 1,2'd0,3'd0,5'd3, 32'd7, 1,0));
    vecs.push_back(row(0,0,0,1,1,2'd1,3'd0,1,32'd4, 5'd2,5'd0,5'd5,  1,0, 1,2'd1,3'd0,5'd5, 32'd4, 1,0));
    vecs.push_back(row(0,0,0,1,1,2'd0,3'd0,0,32'd0, 5'd5,5'd7,5'd6,  1,1, 0,2'd0,3'd0,5'd0, 32'd0, 0,1));
    vecs.push_back(row(0,0,0,1,1,2'd0,3'd0,0,32'd0, 5'd5,5'd7,5'd6,  1,0, 1,2'd0,3'd0,5'd6, 32'd0, 1,0));
    vecs.push_back(row(0,0,0,1,1,2'd1,3'd0,1,32'd0, 5'd0,5'd0,5'd0,  1,0, 1,2'd1,3'd0,5'd0, 32'd0, 1,0));
    vecs.push_back(row(0,0,0,1,1,2'd0,3'd0,0,32'd0, 5'd0,5'd0,5'd8,  1,0, 1,2'd0,3'd0,5'd8, 32'd0, 1,0));
    vecs.push_back(row(0,0,0,1,1,2'd1,3'd0,1,32'd12,5'd1,5'd0,5'd9,  1,0, 1,2'd1,3'd0,5'd9, 32'd12,1,0));
    vecs.push_back(row(0,1,1,1,0,2'd0,3'd2,1,32'd0, 5'd1,5'd9,5'd0,  1,0, 0,2'd0,3'd0,5'd0, 32'd0, 0,1));
    vecs.push_back(row(0,0,0,1,1,2'd0,3'd0,1,32'd11,5'd0,5'd0,5'd11, 1,0, 1,2'd0,3'd0,5'd11,32'd11,1,0));
    vecs.push_back(row(0,0,1,1,1,2'd0,3'd1,1,32'd20,5'd0,5'd0,5'd12, 1,1, 1,2'd0,3'd0,5'd11,32'd11,1,0));
    vecs.push_back(row(0,0,1,1,0,2'd1,3'd0,0,32'd21,5'd0,5'd0,5'd13, 1,1, 1,2'd0,3'd0,5'd11,32'd11,1,0));
    vecs.push_back(row(0,0,1,0,1,2'd0,3'd0,1,32'd22,5'd0,5'd0,5'd14, 1,1, 1,2'd0,3'd0,5'd11,32'd11,1,0));
    vecs.push_back(row(0,0,0,1,1,2'd0,3'd0,1,32'd15,5'd0,5'd0,5'd15, 1,0, 1,2'd0,3'd0,5'd15,32'd15,1,0));
    vecs.push_back(row(0,0,0,0,1,2'd0,3'd3,1,32'd16,5'd0,5'd0,5'd16, 1,0, 0,2'd0,3'd0,5'd16,32'd16,0,0));
    vecs.push_back(row(0,0,0,1,1,2'd1,3'd0,1,32'd0, 5'd1,5'd0,5'd5,  1,0, 1,2'd1,3'd0,5'd5, 32'd0, 1,0));
    vecs.push_back(row(1,0,0,1,1,2'd0,3'd0,0,32'd0, 5'd5,5'd0,5'd6,  1,1, 0,2'd0,3'd0,5'd0, 32'd0, 0,0));
    vecs.push_back(row(0,0,0,1,1,2'd0,3'd0,0,32'd0, 5'd5,5'd0,5'd6,  1,0, 1,2'd0,3'd0,5'd6, 32'd0, 1,0));

    clear_inputs();

    // Directed table
    foreach (vecs[i]) begin
      @(negedge clk);
      clear_inputs();
      rst = vecs[i].rst; FlushE = vecs[i].flush; StallE = vecs[i].stall;
      ValidD = vecs[i].valid; RegWriteD = vecs[i].regw; ResultSrcD = vecs[i].rsrc;
      MemWriteD = vecs[i].memw; ALUSrcD = vecs[i].alusrc; ImmExtD = vecs[i].imm;
      Rs1D = vecs[i].rs1; Rs2D = vecs[i].rs2; RdD = vecs[i].rd;
      #1;
      if (vecs[i].chk_stall) begin
        check1($sformatf("vec%0d StallF", i), StallF, vecs[i].x_stall);
        check1($sformatf("vec%0d StallD", i), StallD, vecs[i].x_stall);
      end
      @(posedge clk);
      #1;
      n_checks++;
      if ({RegWriteE, ResultSrcE, MemWriteE, RdE, ImmExtE, ValidE, BubbleE} !==
          {vecs[i].x_regw, vecs[i].x_rsrc, vecs[i].x_memw, vecs[i].x_rd,
           vecs[i].x_imm, vecs[i].x_valid, vecs[i].x_bubble}) begin
        n_fail++;
        $display("FAIL vec%0d E: got rw=%b rs=%h mw=%h rd=%0d imm=%0d v=%b bub=%b expected rw=%b rs=%h mw=%h rd=%0d imm=%0d v=%b bub=%b",
                 i, RegWriteE, ResultSrcE, MemWriteE, RdE, ImmExtE, ValidE, BubbleE,
                 vecs[i].x_regw, vecs[i].x_rsrc, vecs[i].x_memw, vecs[i].x_rd,
                 vecs[i].x_imm, vecs[i].x_valid, vecs[i].x_bubble);
      end
    end

    // Bring DUT and model into a known common state
    @(negedge clk);
    clear_inputs();
    rst = 1;
    @(posedge clk);
    #1;
    model_e   = '0;
    m_bubbles = 0;
    m_flushes = 0;
    check_e("reset state", dut_e(), model_e);

    // Randomized traffic against the reference model
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      randomize_inputs();
      #1;
      hz        = model_hazard(model_e);
      exp_stall = (hz || StallE) && !FlushE;
      check1($sformatf("rand%0d StallF", cyc), StallF, exp_stall);
      check1($sformatf("rand%0d StallD", cyc), StallD, exp_stall);
      if (rst) begin
        exp_e = '0;
        m_bubbles = 0;
        m_flushes = 0;
      end else if (FlushE) begin
        exp_e = '0;
        exp_e.bubble = 1'b1;
        m_flushes = m_flushes + 1;
      end else if (StallE) begin
        exp_e = model_e;
        exp_e.bubble = 1'b0;
      end else if (hz) begin
        exp_e = '0;
        exp_e.bubble = 1'b1;
        m_bubbles = m_bubbles + 1;
      end else begin
        exp_e = d_as_e();
      end
      model_e = exp_e;
      @(posedge clk);
      #1;
      check_e($sformatf("rand%0d E", cyc), dut_e(), model_e);
`ifdef ID_EX_PERF_CNT_EN
      check1($sformatf("rand%0d BubbleCount", cyc), BubbleCount === m_bubbles, 1'b1);
      check1($sformatf("rand%0d FlushCount", cyc), FlushCount === m_flushes, 1'b1);
`endif
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
